// File: rtl/envelope_detector_param_if.sv
// Sample-in / envelope-out bus of the AM envelope detector.
// ENV_PEAK_EN adds the peak_mode control line.
interface envelope_detector_param_if #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DECIM_W = 8
);
  logic                      clr;
  logic                      in_valid;
  logic signed [IN_W-1:0]    in_data;
  logic [3:0]                shift;
  logic [DECIM_W-1:0]        decim;
`ifdef ENV_PEAK_EN
  logic                      peak_mode;
`endif
  logic [OUT_W-1:0]          env_out;
  logic                      env_valid;

  modport master (
    output clr, in_valid, in_data, shift, decim,
`ifdef ENV_PEAK_EN
    output peak_mode,
`endif
    input  env_out, env_valid
  );

  modport slave (
    input  clr, in_valid, in_data, shift, decim,
`ifdef ENV_PEAK_EN
    input  peak_mode,
`endif
    output env_out, env_valid
  );
endinterface

// File: rtl/envelope_detector_param.sv
// AM envelope detector: rectify -> first-order IIR (pole 1-2^-k) -> decimate.
// Optional ENV_PEAK_EN: peak_mode gives instant attack with IIR decay.
module envelope_detector_param #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned FRAC_W  = 10,
  parameter int unsigned DECIM_W = 8
) (
  input  logic                         clk,
  input  logic                         RSTb,
  envelope_detector_param_if.slave     bus
);
  localparam int unsigned MAG_W = IN_W - 1;
  localparam int unsigned ACC_W = IN_W - 1 + FRAC_W;
  localparam int unsigned KW    = 5;

  logic [MAG_W-1:0]   mag;
  logic               mag_v;
  logic [ACC_W-1:0]   acc;
  logic               acc_v;
  logic [DECIM_W-1:0] cnt;

  logic [IN_W-1:0]    neg_c;
  logic [MAG_W-1:0]   mag_c;
  logic [KW-1:0]      keff_c;
  logic [ACC_W-1:0]   decay_c;
  logic [ACC_W-1:0]   add_c;
  logic [ACC_W:0]     sum_c;
  logic [ACC_W-1:0]   acc_nxt_c;
  logic [OUT_W-1:0]   y_c;

  // Saturating magnitude: the most negative code maps to the largest positive.
  assign neg_c = IN_W'(~bus.in_data) + IN_W'(1);

  always_comb begin
    mag_c = bus.in_data[MAG_W-1:0];
    if (bus.in_data[IN_W-1]) begin
      mag_c = neg_c[IN_W-1] ? '1 : neg_c[MAG_W-1:0];
    end
  end

  always_comb begin
    keff_c = KW'(bus.shift);
    if (bus.shift == 4'd0) begin
      keff_c = KW'(1);
    end else if (32'(bus.shift) > FRAC_W) begin
      keff_c = KW'(FRAC_W);
    end
  end

  // Input scaled by 2^-k keeps unity DC gain against the 2^-k leak.
  assign decay_c = acc >> keff_c;
  assign add_c   = ACC_W'(mag) << (KW'(FRAC_W) - keff_c);
  assign sum_c   = (ACC_W+1)'(acc - decay_c) + (ACC_W+1)'(add_c);

`ifdef ENV_PEAK_EN
  logic [ACC_W-1:0] full_c;
  assign full_c = ACC_W'(mag) << FRAC_W;

  always_comb begin
    acc_nxt_c = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
    if (bus.peak_mode && (full_c > acc)) begin
      acc_nxt_c = full_c;
    end
  end
`else
  always_comb begin
    acc_nxt_c = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
  end
`endif

  assign y_c = OUT_W'(acc[ACC_W-1:FRAC_W]);

  // Stage 1: rectifier.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      mag   <= '0;
      mag_v <= 1'b0;
    end else if (bus.clr) begin
      mag_v <= 1'b0;
    end else begin
      mag_v <= bus.in_valid;
      if (bus.in_valid) begin
        mag <= mag_c;
      end
    end
  end

  // Stage 2: IIR accumulator.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      acc   <= '0;
      acc_v <= 1'b0;
    end else if (bus.clr) begin
      acc   <= '0;
      acc_v <= 1'b0;
    end else begin
      acc_v <= mag_v;
      if (mag_v) begin
        acc <= acc_nxt_c;
      end
    end
  end

  // Decimator; >= lets a lowered ratio release on the next update.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      cnt           <= '0;
      bus.env_out   <= '0;
      bus.env_valid <= 1'b0;
    end else if (bus.clr) begin
      cnt           <= '0;
      bus.env_valid <= 1'b0;
    end else if (acc_v) begin
      if (cnt >= bus.decim) begin
        bus.env_out   <= y_c;
        bus.env_valid <= 1'b1;
        cnt           <= '0;
      end else begin
        cnt           <= cnt + DECIM_W'(1);
        bus.env_valid <= 1'b0;
      end
    end else begin
      bus.env_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_envelope_detector_param.sv
// Directed bench for envelope_detector_param (define ENV_PEAK_EN for the peak test).
module tb_envelope_detector_param;
  localparam int unsigned IN_W    = 8;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned FRAC_W  = 10;
  localparam int unsigned DECIM_W = 8;

  logic clk = 1'b0;
  logic RSTb;
  always #5 clk = ~clk;

  envelope_detector_param_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM_W(DECIM_W)) bus ();

  envelope_detector_param #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W), .DECIM_W(DECIM_W)
  ) dut (
    .clk  (clk),
    .RSTb (RSTb),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [7:0]  pv[$];
  int unsigned pc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: value and cycle stamp of each env_valid pulse.
  always @(negedge clk) begin
    if (bus.env_valid) begin
      pv.push_back(bus.env_out);
      pc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic signed [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.clr      = 1'b0;
  endtask

  task automatic flush_q();
    pv.delete();
    pc.delete();
  endtask

  initial begin
    RSTb         = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.shift    = 4'd1;
    bus.decim    = '0;
`ifdef ENV_PEAK_EN
    bus.peak_mode = 1'b0;
`endif
    #12;
    chk("reset_env_out", 32'(bus.env_out), 32'd0);
    chk("reset_env_valid", 32'(bus.env_valid), 32'd0);
    @(negedge clk);
    RSTb = 1'b1;

    // Full-scale negative input, shift=1, every update emitted.
    flush_q();
    for (int i = 0; i < 24; i++) drive(1'b1, -8'sd128);
    idle(4);
    chk("fs_count", 32'(pv.size()), 32'd24);
    if (pv.size() == 24) begin
      chk("fs_u1", 32'(pv[0]), 32'd63);
      chk("fs_u2", 32'(pv[1]), 32'd95);
      chk("fs_u3", 32'(pv[2]), 32'd111);
      chk("fs_u4", 32'(pv[3]), 32'd119);
      chk("fs_u17", 32'(pv[16]), 32'd127);
      chk("fs_u24_hold", 32'(pv[23]), 32'd127);
      chk("fs_spacing", pc[1] - pc[0], 32'd1);
    end

    // clr together with a valid sample: sample dropped, no pulse, env_out holds.
    flush_q();
    @(negedge clk);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = -8'sd128;
    @(negedge clk);
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    idle(3);
    chk("clr_no_pulse", 32'(pv.size()), 32'd0);
    chk("clr_env_hold", 32'(bus.env_out), 32'd127);
    drive(1'b1, 8'sd64);
    idle(4);
    chk("clr_restart_cnt", 32'(pv.size()), 32'd1);
    if (pv.size() == 1) chk("clr_restart_val", 32'(pv[0]), 32'd32);

    // Sign symmetry, shift=3.
    do_clr();
    bus.shift = 4'd3;
    flush_q();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'sd100);
    idle(4);
    chk("pos_count", 32'(pv.size()), 32'd4);
    if (pv.size() == 4) begin
      chk("pos_u1", 32'(pv[0]), 32'd12);
      chk("pos_u2", 32'(pv[1]), 32'd23);
      chk("pos_u3", 32'(pv[2]), 32'd33);
      chk("pos_u4", 32'(pv[3]), 32'd41);
    end
    do_clr();
    flush_q();
    for (int i = 0; i < 4; i++) drive(1'b1, -8'sd100);
    idle(4);
    chk("neg_count", 32'(pv.size()), 32'd4);
    if (pv.size() == 4) begin
      chk("neg_u1", 32'(pv[0]), 32'd12);
      chk("neg_u2", 32'(pv[1]), 32'd23);
      chk("neg_u3", 32'(pv[2]), 32'd33);
      chk("neg_u4", 32'(pv[3]), 32'd41);
    end

    // Decimation by 4, back-to-back then with one-cycle gaps.
    do_clr();
    bus.shift = 4'd2;
    bus.decim = 8'd3;
    flush_q();
    for (int i = 0; i < 12; i++) drive(1'b1, 8'sd64);
    idle(4);
    chk("dec_count", 32'(pv.size()), 32'd3);
    if (pv.size() == 3) begin
      chk("dec_u4", 32'(pv[0]), 32'd43);
      chk("dec_u8", 32'(pv[1]), 32'd57);
      chk("dec_u12", 32'(pv[2]), 32'd61);
      chk("dec_gap1", pc[1] - pc[0], 32'd4);
      chk("dec_gap2", pc[2] - pc[1], 32'd4);
    end
    do_clr();
    flush_q();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'sd64);
      drive(1'b0, 8'sd0);
    end
    idle(4);
    chk("decs_count", 32'(pv.size()), 32'd3);
    if (pv.size() == 3) begin
      chk("decs_u4", 32'(pv[0]), 32'd43);
      chk("decs_u8", 32'(pv[1]), 32'd57);
      chk("decs_u12", 32'(pv[2]), 32'd61);
      chk("decs_gap1", pc[1] - pc[0], 32'd8);
      chk("decs_gap2", pc[2] - pc[1], 32'd8);
    end

    // Mid-stream asynchronous reset, then single-sample latency.
    do_clr();
    bus.shift = 4'd1;
    bus.decim = 8'd0;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'sd100);
    chk("pre_rst_nonzero", 32'(bus.env_out != 8'd0), 32'd1);
    #2;
    RSTb         = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("async_rst_env_out", 32'(bus.env_out), 32'd0);
    chk("async_rst_env_valid", 32'(bus.env_valid), 32'd0);
    @(negedge clk);
    RSTb = 1'b1;
    drive(1'b1, 8'sd100);
    idle(1);
    chk("lat_e0", 32'(bus.env_valid), 32'd0);
    idle(1);
    chk("lat_e1", 32'(bus.env_valid), 32'd0);
    idle(1);
    chk("lat_e2", 32'(bus.env_valid), 32'd1);
    chk("lat_e2_val", 32'(bus.env_out), 32'd50);
    idle(1);
    chk("lat_e3", 32'(bus.env_valid), 32'd0);

`ifdef ENV_PEAK_EN
    // Peak mode: instant attack, decay at rate 2^-4.
    do_clr();
    bus.shift     = 4'd4;
    bus.decim     = 8'd0;
    bus.peak_mode = 1'b1;
    flush_q();
    drive(1'b1, 8'sd100);
    drive(1'b1, 8'sd0);
    drive(1'b1, 8'sd0);
    idle(4);
    bus.peak_mode = 1'b0;
    chk("peak_count", 32'(pv.size()), 32'd3);
    if (pv.size() == 3) begin
      chk("peak_attack", 32'(pv[0]), 32'd100);
      chk("peak_decay1", 32'(pv[1]), 32'd93);
      chk("peak_decay2", 32'(pv[2]), 32'd87);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
